// File: rtl/mclk_clock_gen.sv
// mclk_clock_gen: divides inclk0 by DIV onto glitch-free registered c0, raising locked LOCK_CYCLES edges after areset release; ports inclk0, areset (async, active-high), c0, locked; `define MCLK_GEN_DUTY50_EN adds a negedge half-cycle register for 50% duty at odd DIV
module mclk_clock_gen #(
  parameter int DIV         = 5,
  parameter int LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic areset,
  output logic c0,
  output logic locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1) < 1 ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam int CW = $clog2(DIV) < 1 ? 1 : $clog2(DIV);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LPRE = LW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [CW-1:0] HV   = CW'(DIV / 2);
  logic [LW-1:0] lcnt;
  logic [CW-1:0] cnt;
  logic          p;
  if (DIV < 2 || LOCK_CYCLES < 1) begin : g_bad_params
    $error("mclk_clock_gen: DIV must be >= 2 and LOCK_CYCLES >= 1");
  end
  always_ff @(posedge inclk0 or posedge areset)
    if (areset) begin
      lcnt   <= '0;
      locked <= 1'b0;
      cnt    <= '0;
      p      <= 1'b0;
    end else begin
      lcnt   <= (lcnt == LMAX) ? lcnt : lcnt + LW'(1);
      locked <= locked | (lcnt == LPRE);
      cnt    <= (!locked || cnt == CMAX) ? '0 : cnt + CW'(1);
      p      <= locked && (cnt < HV);
    end
`ifdef MCLK_GEN_DUTY50_EN
  if (DIV % 2 == 1) begin : g_odd
    logic n;
    always_ff @(negedge inclk0 or posedge areset)
      if (areset) n <= 1'b0;
      else n <= p;
    always_comb c0 = p | n;
  end else begin : g_even
    always_comb c0 = p;
  end
`else
  always_comb c0 = p;
`endif
endmodule

// File: tb/tb_mclk_clock_gen.sv
// tb_mclk_clock_gen: directed checks of lock timing, c0 period/duty, edge count and async reset for DIV=5 and DIV=4
`timescale 1ns/1ps
module tb_mclk_clock_gen;
  logic inclk0 = 1'b0;
  logic areset = 1'b1;
  logic c0, locked, c0_4, locked_4;
  int n_checks = 0;
  int n_fail = 0;
`ifdef MCLK_GEN_DUTY50_EN
  localparam int HI5 = 50;
`else
  localparam int HI5 = 40;
`endif
  realtime r5 = 0.0;
  realtime r4 = 0.0;
  int per5 = 0, hi5 = 0, n5 = 0;
  int per4 = 0, hi4 = 0, n4 = 0;
  mclk_clock_gen #(.DIV(5), .LOCK_CYCLES(16)) u_dut (
    .inclk0(inclk0),
    .areset(areset),
    .c0(c0),
    .locked(locked)
  );
  mclk_clock_gen #(.DIV(4), .LOCK_CYCLES(16)) u_dut4 (
    .inclk0(inclk0),
    .areset(areset),
    .c0(c0_4),
    .locked(locked_4)
  );
  always #10 inclk0 = ~inclk0;
  always @(posedge c0) begin
    per5 <= int'($realtime - r5);
    r5   <= $realtime;
    n5   <= n5 + 1;
  end
  always @(negedge c0) hi5 <= int'($realtime - r5);
  always @(posedge c0_4) begin
    per4 <= int'($realtime - r4);
    r4   <= $realtime;
    n4   <= n4 + 1;
  end
  always @(negedge c0_4) hi4 <= int'($realtime - r4);
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic lock_seq(input string tag);
    logic bad;
    bad = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge inclk0);
      #1;
      if (k < 16) bad = bad | (locked !== 1'b0) | (locked_4 !== 1'b0);
      if (k <= 16) bad = bad | (c0 !== 1'b0) | (c0_4 !== 1'b0);
      if (k == 16) begin
        check({tag, "_locked5_at16"}, int'(locked === 1'b1), 1);
        check({tag, "_locked4_at16"}, int'(locked_4 === 1'b1), 1);
      end
      if (k == 17) begin
        check({tag, "_c0_5_rise17"}, int'(c0 === 1'b1), 1);
        check({tag, "_c0_4_rise17"}, int'(c0_4 === 1'b1), 1);
      end
    end
    check({tag, "_quiet_before_lock"}, int'(bad), 0);
  endtask
  initial begin
    logic bad;
    int s5, s4;
    bad = 1'b0;
    repeat (10) begin
      @(negedge inclk0);
      bad = bad | (c0 !== 1'b0) | (locked !== 1'b0) | (c0_4 !== 1'b0) | (locked_4 !== 1'b0);
    end
    check("reset_hold", int'(bad), 0);
    areset = 1'b0;
    lock_seq("lock1");
    repeat (30) @(negedge inclk0);
    check("period5", per5, 100);
    check("high5", hi5, HI5);
    check("period4", per4, 80);
    check("high4", hi4, 40);
    s5 = n5;
    s4 = n4;
    repeat (1000) @(negedge inclk0);
    check("rises5_1000", n5 - s5, 200);
    check("rises4_1000", n4 - s4, 250);
    for (int i = 0; i < 10 && c0 !== 1'b1; i++) @(negedge inclk0);
    check("c0_high_before_rst", int'(c0 === 1'b1), 1);
    #3;
    areset = 1'b1;
    #0.1;
    check("rst_c0_5", int'(c0 === 1'b0), 1);
    check("rst_locked5", int'(locked === 1'b0), 1);
    check("rst_locked4", int'(locked_4 === 1'b0), 1);
    repeat (3) @(negedge inclk0);
    areset = 1'b0;
    lock_seq("lock2");
    repeat (30) @(negedge inclk0);
    check("relock_period5", per5, 100);
    check("relock_high5", hi5, HI5);
    check("relock_period4", per4, 80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
